datapath_controller: RTL and testbench

- Multicycle FSM that sequences the 16-bit datapath: fetch, decode, execute, memory and writeback.
- Decodes op_code/ext_op_code and drives every datapath select and enable.
- Holds the architectural PSR flag register, resolves branch conditions and handshakes with instruction and data memory.

---
 rtl/datapath_controller_if.sv | 38 +++
 rtl/datapath_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_datapath_controller.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_controller_if.sv
// Control/status bundle between the multicycle controller and the 16-bit datapath.
// The master side is the controller, the slave side is the datapath and memories.
interface datapath_controller_if #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 6,
    parameter int OP_BITS       = 4
);
    logic [OP_BITS-1:0]       op_code;
    logic [OP_BITS-1:0]       ext_op_code;
    logic [OP_BITS-1:0]       cond;
    logic [WIDTH-1:0]         alu_psr;
    logic                     imem_ready;
    logic                     dmem_ready;
    logic                     pc_en;
    logic                     reg_write;
    logic                     alu_A_src;
    logic                     alu_B_src;
    logic [1:0]               pc_src;
    logic [1:0]               reg_write_src;
    logic [ALU_CONT_BITS-1:0] alu_cont;
    logic                     mem_read;
    logic                     mem_write;
    logic [WIDTH-1:0]         psr_q;
    logic                     instr_done;
    logic                     illegal;

    modport master (
        input  op_code, ext_op_code, cond, alu_psr, imem_ready, dmem_ready,
        output pc_en, reg_write, alu_A_src, alu_B_src, pc_src, reg_write_src,
               alu_cont, mem_read, mem_write, psr_q, instr_done, illegal
    );

    modport slave (
        output op_code, ext_op_code, cond, alu_psr, imem_ready, dmem_ready,
        input  pc_en, reg_write, alu_A_src, alu_B_src, pc_src, reg_write_src,
               alu_cont, mem_read, mem_write, psr_q, instr_done, illegal
    );
endinterface

// File: rtl/datapath_controller.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer for the 16-bit datapath.
// Owns the PSR flags, resolves branch conditions and handshakes with both memories.
module datapath_controller #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 6,
    parameter int OP_BITS       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    datapath_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC, WB, MEM_LD, MEM_ST,
        BR_EX, BR_WB, JUMP, JAL, RETIRE, ILLEGAL
    } state_t;

    localparam logic [ALU_CONT_BITS-1:0] ALU_ADD   = ALU_CONT_BITS'(0);
    localparam logic [ALU_CONT_BITS-1:0] ALU_SUB   = ALU_CONT_BITS'(1);
    localparam logic [ALU_CONT_BITS-1:0] ALU_AND   = ALU_CONT_BITS'(2);
    localparam logic [ALU_CONT_BITS-1:0] ALU_OR    = ALU_CONT_BITS'(3);
    localparam logic [ALU_CONT_BITS-1:0] ALU_XOR   = ALU_CONT_BITS'(4);
    localparam logic [ALU_CONT_BITS-1:0] ALU_PASSB = ALU_CONT_BITS'(5);

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 6;
    localparam int FLAG_N = 7;

    typedef struct packed {
        logic                     pc_en;
        logic                     reg_write;
        logic                     alu_a_src;
        logic                     alu_b_src;
        logic [1:0]               pc_src;
        logic [1:0]               reg_write_src;
        logic [ALU_CONT_BITS-1:0] alu_cont;
        logic                     mem_read;
        logic                     mem_write;
        logic                     instr_done;
        logic                     illegal;
    } ctrl_t;

    state_t                   state;
    state_t                   nxt;
    state_t                   dec_next;
    ctrl_t                    ctrl_q;
    logic [WIDTH-1:0]         psr_q;
    logic                     cmp_q;
    logic                     taken;
    logic                     dec_imm;
    logic                     dec_cmp;
    logic [ALU_CONT_BITS-1:0] dec_alu;
    logic [ALU_CONT_BITS+1:0] alu_r;
    logic [ALU_CONT_BITS+1:0] alu_i;
    logic                     ld_done;
    logic                     st_done;
    logic                     unused_psr_bits;

    // {legal, is_cmp, alu_cont} for an ALU function code
    function automatic logic [ALU_CONT_BITS+1:0] alu_map(input logic [OP_BITS-1:0] code);
        case (code)
            4'b0101: return {1'b1, 1'b0, ALU_ADD};
            4'b1001: return {1'b1, 1'b0, ALU_SUB};
            4'b1011: return {1'b1, 1'b1, ALU_SUB};
            4'b0001: return {1'b1, 1'b0, ALU_AND};
            4'b0010: return {1'b1, 1'b0, ALU_OR};
            4'b0011: return {1'b1, 1'b0, ALU_XOR};
            4'b1101: return {1'b1, 1'b0, ALU_PASSB};
            default: return '0;
        endcase
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s, input logic tk, input logic imm,
                                       input logic [ALU_CONT_BITS-1:0] aop);
        ctrl_t c;
        c = '0;
        case (s)
            EXEC: begin
                c.alu_a_src = 1'b1;
                c.alu_b_src = imm;
                c.alu_cont  = aop;
            end
            WB: begin
                c.reg_write  = 1'b1;
                c.pc_en      = 1'b1;
                c.pc_src     = 2'd2;
                c.instr_done = 1'b1;
            end
            MEM_LD: c.mem_read  = 1'b1;
            MEM_ST: c.mem_write = 1'b1;
            BR_EX:  c.alu_b_src = 1'b1;
            BR_WB: begin
                c.pc_en      = 1'b1;
                c.pc_src     = tk ? 2'd0 : 2'd2;
                c.instr_done = 1'b1;
            end
            JUMP: begin
                c.pc_en      = 1'b1;
                c.pc_src     = tk ? 2'd1 : 2'd2;
                c.instr_done = 1'b1;
            end
            JAL: begin
                c.reg_write     = 1'b1;
                c.reg_write_src = 2'd2;
                c.pc_en         = 1'b1;
                c.pc_src        = 2'd1;
                c.instr_done    = 1'b1;
            end
            RETIRE: begin
                c.pc_en      = 1'b1;
                c.pc_src     = 2'd2;
                c.instr_done = 1'b1;
            end
            ILLEGAL: begin
                c.pc_en   = 1'b1;
                c.pc_src  = 2'd2;
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign alu_r = alu_map(bus.ext_op_code);
    assign alu_i = alu_map(bus.op_code);

    always_comb begin
        dec_next = ILLEGAL;
        dec_imm  = 1'b0;
        dec_cmp  = 1'b0;
        dec_alu  = ALU_ADD;
        if (bus.op_code == 4'b0000) begin
            if (alu_r[ALU_CONT_BITS+1]) begin
                dec_next = EXEC;
                dec_cmp  = alu_r[ALU_CONT_BITS];
                dec_alu  = alu_r[ALU_CONT_BITS-1:0];
            end
        end else if (bus.op_code == 4'b0100) begin
            case (bus.ext_op_code)
                4'b0000: dec_next = MEM_LD;
                4'b0100: dec_next = MEM_ST;
                4'b1000: dec_next = JAL;
                4'b1100: dec_next = JUMP;
                default: dec_next = ILLEGAL;
            endcase
        end else if (bus.op_code == 4'b1100) begin
            dec_next = BR_EX;
        end else if (alu_i[ALU_CONT_BITS+1]) begin
            dec_next = EXEC;
            dec_imm  = 1'b1;
            dec_cmp  = alu_i[ALU_CONT_BITS];
            dec_alu  = alu_i[ALU_CONT_BITS-1:0];
        end
    end

    // Conditions look only at the latched flags, never at the live ALU flags
    always_comb begin
        case (bus.cond)
            4'b0000: taken = psr_q[FLAG_Z];
            4'b0001: taken = ~psr_q[FLAG_Z];
            4'b0010: taken = psr_q[FLAG_C];
            4'b0011: taken = ~psr_q[FLAG_C];
            4'b0110: taken = psr_q[FLAG_N];
            4'b0111: taken = ~psr_q[FLAG_N];
            4'b1110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            FETCH:   nxt = bus.imem_ready ? DECODE : FETCH;
            DECODE:  nxt = dec_next;
            EXEC:    nxt = cmp_q ? RETIRE : WB;
            BR_EX:   nxt = BR_WB;
            MEM_LD:  nxt = bus.dmem_ready ? FETCH : MEM_LD;
            MEM_ST:  nxt = bus.dmem_ready ? FETCH : MEM_ST;
            default: nxt = FETCH;
        endcase
    end

    // Outputs are registered by decoding the state being entered; the operands they
    // depend on (decode, taken) are valid in the cycle that makes the transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= FETCH;
            ctrl_q <= '0;
            psr_q  <= '0;
            cmp_q  <= 1'b0;
        end else begin
            state  <= nxt;
            ctrl_q <= ctrl_for(nxt, taken, dec_imm, dec_alu);
            if (state == DECODE)
                cmp_q <= dec_cmp;
            if (state == EXEC && (ctrl_q.alu_cont == ALU_ADD || ctrl_q.alu_cont == ALU_SUB)) begin
                psr_q[FLAG_C] <= bus.alu_psr[FLAG_C];
                psr_q[FLAG_Z] <= bus.alu_psr[FLAG_Z];
                psr_q[FLAG_N] <= bus.alu_psr[FLAG_N];
            end
        end
    end

    // Memory completion reacts to dmem_ready within the same cycle
    assign ld_done = reset && bus.dmem_ready && (state == MEM_LD);
    assign st_done = reset && bus.dmem_ready && (state == MEM_ST);

    assign bus.pc_en         = ctrl_q.pc_en | ld_done | st_done;
    assign bus.pc_src        = ctrl_q.pc_src | ((ld_done || st_done) ? 2'd2 : 2'd0);
    assign bus.reg_write     = ctrl_q.reg_write | ld_done;
    assign bus.reg_write_src = ctrl_q.reg_write_src | {1'b0, ld_done};
    assign bus.alu_A_src     = ctrl_q.alu_a_src;
    assign bus.alu_B_src     = ctrl_q.alu_b_src;
    assign bus.alu_cont      = ctrl_q.alu_cont;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.instr_done    = ctrl_q.instr_done | ld_done | st_done;
    assign bus.illegal       = ctrl_q.illegal;
    assign bus.psr_q         = psr_q;

    assign unused_psr_bits = ^{bus.alu_psr[WIDTH-1:FLAG_N+1], bus.alu_psr[FLAG_Z-1:FLAG_C+1]};

endmodule

// File: tb/tb_datapath_controller.sv
// Randomized scoreboard bench for datapath_controller: a driver issues instructions and
// queues the expected retirement; an independent monitor checks every retire/exec cycle.
module tb_datapath_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    datapath_controller_if #(.WIDTH(16), .ALU_CONT_BITS(6), .OP_BITS(4)) bus ();
    datapath_controller #(.WIDTH(16), .ALU_CONT_BITS(6), .OP_BITS(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int total = 0;
    int bad = 0;

    typedef enum {K_ALU, K_LD, K_ST, K_JAL, K_JC, K_BC, K_ILL} kind_t;

    typedef struct {
        bit        ill;
        int        lat;
        bit [1:0]  pc_src;
        bit [1:0]  rw_src;
        int        n_rw;
        int        n_rd;
        int        n_wr;
        bit [15:0] psr;
        bit        has_exec;
        bit [5:0]  alu;
        bit        bsrc;
    } exp_t;

    exp_t      sb[$];
    exp_t      mon_e;
    bit [15:0] psr_m = '0;

    int alu_codes[7] = '{5, 9, 11, 1, 2, 3, 13};
    int alu_ops[7]   = '{0, 1, 1, 2, 3, 4, 5};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int alu_idx(input logic [3:0] c);
        for (int i = 0; i < 7; i++)
            if (alu_codes[i] == int'(c)) return i;
        return -1;
    endfunction

    function automatic kind_t classify(input logic [15:0] ir, output int ai, output bit imm);
        imm = 1'b0;
        ai = -1;
        if (ir[15:12] == 4'h0) begin
            ai = alu_idx(ir[7:4]);
            return (ai >= 0) ? K_ALU : K_ILL;
        end
        if (ir[15:12] == 4'h4) begin
            case (ir[7:4])
                4'h0: return K_LD;
                4'h4: return K_ST;
                4'h8: return K_JAL;
                4'hC: return K_JC;
                default: return K_ILL;
            endcase
        end
        if (ir[15:12] == 4'hC) return K_BC;
        ai = alu_idx(ir[15:12]);
        imm = 1'b1;
        return (ai >= 0) ? K_ALU : K_ILL;
    endfunction

    function automatic bit cond_true(input logic [3:0] c, input bit [15:0] p);
        case (c)
            4'h0: return p[6];
            4'h1: return !p[6];
            4'h2: return p[0];
            4'h3: return !p[0];
            4'h6: return p[7];
            4'h7: return !p[7];
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic issue(input logic [15:0] ir, input logic [15:0] ap, input int fw, input int mw);
        exp_t  e;
        kind_t k;
        int    ai;
        bit    imm;
        bit    tk;
        bit    is_mem;
        k = classify(ir, ai, imm);
        tk = cond_true(ir[11:8], psr_m);
        is_mem = (k == K_LD) || (k == K_ST);
        e.ill = 0; e.n_rw = 0; e.n_rd = 0; e.n_wr = 0; e.rw_src = 0; e.pc_src = 2;
        e.has_exec = 0; e.alu = 0; e.bsrc = 0;
        case (k)
            K_ALU: begin
                e.lat = fw + 4;
                e.has_exec = 1;
                e.alu = 6'(alu_ops[ai]);
                e.bsrc = imm;
                if (alu_codes[ai] != 11) e.n_rw = 1;
                if (ai <= 2) psr_m = (psr_m & ~16'h00C1) | (ap & 16'h00C1);
            end
            K_LD: begin e.lat = fw + 3 + mw; e.n_rd = mw + 1; e.n_rw = 1; e.rw_src = 1; end
            K_ST: begin e.lat = fw + 3 + mw; e.n_wr = mw + 1; end
            K_JAL: begin e.lat = fw + 3; e.n_rw = 1; e.rw_src = 2; e.pc_src = 1; end
            K_JC: begin e.lat = fw + 3; e.pc_src = tk ? 2'd1 : 2'd2; end
            K_BC: begin e.lat = fw + 4; e.pc_src = tk ? 2'd0 : 2'd2; end
            default: begin e.lat = fw + 3; e.ill = 1; end
        endcase
        e.psr = psr_m;
        sb.push_back(e);
        bus.op_code = ir[15:12];
        bus.cond = ir[11:8];
        bus.ext_op_code = ir[7:4];
        bus.alu_psr = ap;
        for (int c = 0; c < e.lat; c++) begin
            bus.imem_ready = (c == fw) ? 1'b1 : ((c < fw) ? 1'b0 : 1'($urandom_range(0, 1)));
            bus.dmem_ready = is_mem ? (c == fw + 2 + mw) : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.pc_en, bus.reg_write, bus.alu_A_src, bus.alu_B_src, bus.pc_src,
                     bus.reg_write_src, bus.alu_cont, bus.mem_read, bus.mem_write,
                     bus.instr_done, bus.illegal, bus.psr_q}, 32'h0);
    endtask

    // STOR that never completes, aborted by a reset while waiting in the memory phase
    task automatic abort_store();
        bus.op_code = 4'h4; bus.cond = 4'h0; bus.ext_op_code = 4'h4;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("st_mem_write_active", bus.mem_write, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_all_zero("abort_outputs");
        psr_m = '0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    int lat_c = 0, n_rd = 0, n_wr = 0, n_rw = 0, n_pc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            lat_c = 0; n_rd = 0; n_wr = 0; n_rw = 0; n_pc = 0;
        end else begin
            lat_c++;
            n_rd += int'(bus.mem_read);
            n_wr += int'(bus.mem_write);
            n_rw += int'(bus.reg_write);
            n_pc += int'(bus.pc_en);
            if (bus.alu_A_src) begin
                if (sb.size() == 0 || !sb[0].has_exec) begin
                    total++; bad++;
                    $display("FAIL exec_unexpected: got alu_A_src=1 expected 0 at %0t", $time);
                end else begin
                    check("exec_alu_cont", bus.alu_cont, sb[0].alu);
                    check("exec_alu_B_src", bus.alu_B_src, sb[0].bsrc);
                end
            end
            if (bus.instr_done || bus.illegal) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_retire: got retire pulse expected none at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("retire_kind", {bus.instr_done, bus.illegal}, mon_e.ill ? 2'b01 : 2'b10);
                    check("latency", lat_c, mon_e.lat);
                    check("pc_src", bus.pc_src, mon_e.pc_src);
                    check("reg_write_src", bus.reg_write_src, mon_e.rw_src);
                    check("reg_write_cycles", n_rw, mon_e.n_rw);
                    check("pc_en_cycles", n_pc, 1);
                    check("mem_read_cycles", n_rd, mon_e.n_rd);
                    check("mem_write_cycles", n_wr, mon_e.n_wr);
                    check("psr_q", bus.psr_q, mon_e.psr);
                end
                lat_c = 0; n_rd = 0; n_wr = 0; n_rw = 0; n_pc = 0;
            end
        end
    end

    logic [15:0] ir;
    int          sel;
    int          ai;

    initial begin
        bus.op_code = '0; bus.cond = '0; bus.ext_op_code = '0; bus.alu_psr = '0;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("reset_outputs");
        end
        @(posedge clk); #1;
        reset = 1'b1;

        issue(16'h0251, 16'h0040, 0, 0);
        issue(16'h4301, 16'($urandom), 0, 2);
        issue(16'h01B2, 16'h0040, 1, 0);
        issue(16'hC005, 16'($urandom), 0, 0);
        issue(16'h01B2, 16'h0081, 0, 0);
        issue(16'hC005, 16'($urandom), 0, 0);
        issue(16'hCF05, 16'($urandom), 0, 0);
        issue(16'h4E80, 16'($urandom), 0, 0);
        issue(16'h4EC0, 16'($urandom), 2, 0);
        issue(16'h5123, 16'h00C1, 0, 0);
        issue(16'h00D0, 16'h0000, 0, 0);
        issue(16'hF000, 16'($urandom), 0, 0);
        issue(16'h4340, 16'($urandom), 0, 1);
        abort_store();
        issue(16'h0251, 16'h0001, 0, 0);

        for (int n = 0; n < 160; n++) begin
            sel = $urandom_range(0, 7);
            ai = $urandom_range(0, 6);
            ir = 16'($urandom);
            case (sel)
                0: begin ir[15:12] = 4'h0; ir[7:4] = 4'(alu_codes[ai]); end
                1: ir[15:12] = 4'(alu_codes[ai]);
                2: begin ir[15:12] = 4'h4; ir[7:4] = 4'h0; end
                3: begin ir[15:12] = 4'h4; ir[7:4] = 4'h4; end
                4: begin ir[15:12] = 4'h4; ir[7:4] = 4'h8; end
                5: begin ir[15:12] = 4'h4; ir[7:4] = 4'hC; end
                6: ir[15:12] = 4'hC;
                default: ;
            endcase
            issue(ir, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        bus.imem_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
